// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback commit buffer.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;

    // One buffered register-file write.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Which producer wins the single entry slot this cycle.
    typedef enum logic {
        WB_SRC_LD  = 1'b0,
        WB_SRC_ALU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_commit_buffer_if.sv
// Bus bundle for wb_commit_buffer: producer handshakes, register-file write port,
// forwarding lookup and occupancy. slave = buffer side, master = surrounding pipeline.
interface wb_commit_buffer_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DEPTH         = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                     ld_valid;
    logic                     ld_ready;
    logic [ADDRESS_WIDTH-1:0] ld_dest;
    logic [DATA_WIDTH-1:0]    ld_data;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [ADDRESS_WIDTH-1:0] alu_dest;
    logic [DATA_WIDTH-1:0]    alu_data;

    logic                     rg_wrt_en;
    logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
    logic [DATA_WIDTH-1:0]    rg_wrt_data;

    logic [ADDRESS_WIDTH-1:0] fwd_addr1;
    logic [ADDRESS_WIDTH-1:0] fwd_addr2;
    logic                     fwd_hit1;
    logic                     fwd_hit2;
    logic [DATA_WIDTH-1:0]    fwd_data1;
    logic [DATA_WIDTH-1:0]    fwd_data2;

    logic [CNT_W-1:0]         count;

    modport slave (
        input  ld_valid, ld_dest, ld_data,
        input  alu_valid, alu_dest, alu_data,
        input  fwd_addr1, fwd_addr2,
        output ld_ready, alu_ready,
        output rg_wrt_en, rg_wrt_dest, rg_wrt_data,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        output count
    );

    modport master (
        output ld_valid, ld_dest, ld_data,
        output alu_valid, alu_dest, alu_data,
        output fwd_addr1, fwd_addr2,
        input  ld_ready, alu_ready,
        input  rg_wrt_en, rg_wrt_dest, rg_wrt_data,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        input  count
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order circular buffer of wb_entry_t. Exposes storage, per-entry valid bits and
// the head pointer so the owner can run an age-ordered forwarding search.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  wb_entry_t                  push_entry_i,
    input  logic                       pop_i,
    output wb_entry_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output wb_entry_t                  entries_o [DEPTH],
    output logic [DEPTH-1:0]           valid_o,
    output logic [$clog2(DEPTH)-1:0]   head_ptr_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               push_ok, pop_ok;

    assign push_ok = push_i && (count_q != FULL_CNT);
    assign pop_ok  = pop_i && (count_q != '0);

    // Next pointer/count/valid state; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop_ok) begin
            head_d          = head_q + 1'b1;
            valid_d[head_q] = 1'b0;
        end
        if (push_ok) begin
            tail_d          = tail_q + 1'b1;
            valid_d[tail_q] = 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry storage; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    assign head_o     = mem_q[head_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == FULL_CNT);
    assign entries_o  = mem_q;
    assign valid_o    = valid_q;
    assign head_ptr_o = head_q;

endmodule

// File: rtl/wb_commit_buffer.sv
// Writeback commit buffer: arbitrates load/ALU results into an in-order FIFO, drains one
// entry per cycle into a registered register-file write port, and offers a forwarding
// lookup over in-flight writes. Optional feature macro: WB_FWD_EN (forwarding search).
module wb_commit_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = WB_DATA_W,
    parameter int unsigned ADDRESS_WIDTH = WB_ADDR_W,
    parameter int unsigned DEPTH         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_commit_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_src_e                  src;
    logic                     in_valid;
    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     full;
    wb_entry_t                in_entry;
    wb_entry_t                head_entry;
    wb_entry_t                entries [DEPTH];
    logic [DEPTH-1:0]         valid_vec;
    logic [PTR_W-1:0]         head_ptr;
    logic [CNT_W-1:0]         count;

    logic                     rg_wrt_en_q,   rg_wrt_en_d;
    logic [ADDRESS_WIDTH-1:0] rg_wrt_dest_q, rg_wrt_dest_d;
    logic [DATA_WIDTH-1:0]    rg_wrt_data_q, rg_wrt_data_d;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_entry_i(in_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (count),
        .full_o      (full),
        .entries_o   (entries),
        .valid_o     (valid_vec),
        .head_ptr_o  (head_ptr)
    );

    // Entry arbiter: load wins; x0 writes complete the handshake but are not stored.
    always_comb begin
        src      = bus.ld_valid ? WB_SRC_LD : WB_SRC_ALU;
        in_valid = bus.ld_valid || bus.alu_valid;
        in_entry = '0;
        case (src)
            WB_SRC_LD:  in_entry = '{dest: bus.ld_dest,  data: bus.ld_data};
            WB_SRC_ALU: in_entry = '{dest: bus.alu_dest, data: bus.alu_data};
            default:    in_entry = '0;
        endcase
        accept = rst_n && in_valid && !full;
        push   = accept && (in_entry.dest != '0);
        pop    = (count != '0);
    end

    // Readiness ignores a same-cycle pop, so a full buffer never passes a result through.
    assign bus.ld_ready  = rst_n && !full;
    assign bus.alu_ready = rst_n && !full && !bus.ld_valid;
    assign bus.count     = count;

    // Output stage next state: pulse enable per pop, hold address/data when idle.
    always_comb begin
        rg_wrt_en_d   = pop;
        rg_wrt_dest_d = rg_wrt_dest_q;
        rg_wrt_data_d = rg_wrt_data_q;
        if (pop) begin
            rg_wrt_dest_d = head_entry.dest;
            rg_wrt_data_d = head_entry.data;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rg_wrt_en_q   <= 1'b0;
            rg_wrt_dest_q <= '0;
            rg_wrt_data_q <= '0;
        end else begin
            rg_wrt_en_q   <= rg_wrt_en_d;
            rg_wrt_dest_q <= rg_wrt_dest_d;
            rg_wrt_data_q <= rg_wrt_data_d;
        end
    end

    assign bus.rg_wrt_en   = rg_wrt_en_q;
    assign bus.rg_wrt_dest = rg_wrt_dest_q;
    assign bus.rg_wrt_data = rg_wrt_data_q;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Forwarding search: output stage first, then FIFO head-to-tail so the youngest match
    // is the last one written.
    always_comb begin
        bus.fwd_hit1  = 1'b0;
        bus.fwd_hit2  = 1'b0;
        bus.fwd_data1 = '0;
        bus.fwd_data2 = '0;
        fwd_idx       = head_ptr;
        if (rg_wrt_en_q && (rg_wrt_dest_q == bus.fwd_addr1)) begin
            bus.fwd_hit1  = 1'b1;
            bus.fwd_data1 = rg_wrt_data_q;
        end
        if (rg_wrt_en_q && (rg_wrt_dest_q == bus.fwd_addr2)) begin
            bus.fwd_hit2  = 1'b1;
            bus.fwd_data2 = rg_wrt_data_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_ptr + PTR_W'(i);
            if (valid_vec[fwd_idx] && (entries[fwd_idx].dest == bus.fwd_addr1)) begin
                bus.fwd_hit1  = 1'b1;
                bus.fwd_data1 = entries[fwd_idx].data;
            end
            if (valid_vec[fwd_idx] && (entries[fwd_idx].dest == bus.fwd_addr2)) begin
                bus.fwd_hit2  = 1'b1;
                bus.fwd_data2 = entries[fwd_idx].data;
            end
        end
        if (bus.fwd_addr1 == '0) begin
            bus.fwd_hit1  = 1'b0;
            bus.fwd_data1 = '0;
        end
        if (bus.fwd_addr2 == '0) begin
            bus.fwd_hit2  = 1'b0;
            bus.fwd_data2 = '0;
        end
    end
`else
    logic fwd_unused;

    // No forwarding: decode stalls on pending destinations; lookup inputs are ignored.
    always_comb begin
        fwd_unused = ^{bus.fwd_addr1, bus.fwd_addr2, valid_vec, head_ptr};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_unused = fwd_unused ^ (^entries[i]);
        end
    end

    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Self-checking bench for wb_commit_buffer: queue-based reference model, per-cycle
// compare process, directed scenarios plus randomized traffic and resets.
module tb_wb_commit_buffer;
    import wb_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } mentry_t;

    logic clk;
    logic rst_n;

    wb_commit_buffer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    wb_commit_buffer #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int      n_checks = 0;
    int      n_fail   = 0;
    bit      chk_en   = 1'b0;
    bit      fwd_on;

    mentry_t mq[$];
    logic          m_en   = 1'b0;
    logic [AW-1:0] m_dest = '0;
    logic [DW-1:0] m_data = '0;

    initial begin
`ifdef WB_FWD_EN
        fwd_on = 1'b1;
`else
        fwd_on = 1'b0;
`endif
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: what the buffer holds and what the write port shows, updated per edge.
    task automatic model_step();
        int unsigned sz = mq.size();
        if (!rst_n) begin
            mq.delete();
            m_en   = 1'b0;
            m_dest = '0;
            m_data = '0;
        end else begin
            if (sz > 0) begin
                m_en   = 1'b1;
                m_dest = mq[0].dest;
                m_data = mq[0].data;
                mq.delete(0);
            end else begin
                m_en = 1'b0;
            end
            if (sz < DEPTH) begin
                if (bus.ld_valid) begin
                    if (bus.ld_dest != 0) mq.push_back('{bus.ld_dest, bus.ld_data});
                end else if (bus.alu_valid && bus.alu_dest != 0) begin
                    mq.push_back('{bus.alu_dest, bus.alu_data});
                end
            end
        end
    endtask

    task automatic model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (fwd_on && a != 0) begin
            if (m_en && m_dest == a) begin
                hit = 1'b1;
                d   = m_data;
            end
            foreach (mq[i]) begin
                if (mq[i].dest == a) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                end
            end
        end
    endtask

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        logic          h1, h2;
        logic [DW-1:0] d1, d2;
        if (chk_en) begin
            model_fwd(bus.fwd_addr1, h1, d1);
            model_fwd(bus.fwd_addr2, h2, d2);
            check("ld_ready",    64'(bus.ld_ready),    64'(rst_n && mq.size() < DEPTH));
            check("alu_ready",   64'(bus.alu_ready),   64'(rst_n && mq.size() < DEPTH && !bus.ld_valid));
            check("count",       64'(bus.count),       64'(mq.size()));
            check("rg_wrt_en",   64'(bus.rg_wrt_en),   64'(m_en));
            check("rg_wrt_dest", 64'(bus.rg_wrt_dest), 64'(m_dest));
            check("rg_wrt_data", 64'(bus.rg_wrt_data), 64'(m_data));
            check("fwd_hit1",    64'(bus.fwd_hit1),    64'(h1));
            check("fwd_data1",   64'(bus.fwd_data1),   64'(d1));
            check("fwd_hit2",    64'(bus.fwd_hit2),    64'(h2));
            check("fwd_data2",   64'(bus.fwd_data2),   64'(d2));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b0;
        bus.ld_dest   = '0;
        bus.alu_dest  = '0;
        bus.ld_data   = '0;
        bus.alu_data  = '0;
    endtask

    task automatic alu_push(input logic [AW-1:0] d, input logic [DW-1:0] v);
        bus.alu_valid = 1'b1;
        bus.alu_dest  = d;
        bus.alu_data  = v;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.fwd_addr1 = '0;
        bus.fwd_addr2 = '0;

        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_en",    64'(bus.rg_wrt_en),   64'd0);
        check("rst_dest",  64'(bus.rg_wrt_dest), 64'd0);
        check("rst_data",  64'(bus.rg_wrt_data), 64'd0);
        check("rst_count", 64'(bus.count),       64'd0);
        check("rst_ready", 64'(bus.ld_ready),    64'd0);
        rst_n = 1'b1;
        tick();

        // Single ALU write, two-cycle latency, one-cycle pulse
        alu_push(5'd5, 32'hDEAD_BEEF);
        #1 check("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
        tick();
        idle_inputs();
        check("t1_en_n1", 64'(bus.rg_wrt_en), 64'd0);
        tick();
        check("t1_en",   64'(bus.rg_wrt_en),   64'd1);
        check("t1_dest", 64'(bus.rg_wrt_dest), 64'd5);
        check("t1_data", 64'(bus.rg_wrt_data), 64'hDEAD_BEEF);
        tick();
        check("t1_en_off", 64'(bus.rg_wrt_en), 64'd0);

        // Load beats ALU; ALU follows on the next cycle
        bus.ld_valid = 1'b1; bus.ld_dest = 5'd3; bus.ld_data = 32'h11;
        alu_push(5'd4, 32'h22);
        #1 check("t2_ld_ready",  64'(bus.ld_ready),  64'd1);
        check("t2_alu_ready", 64'(bus.alu_ready), 64'd0);
        tick();
        bus.ld_valid = 1'b0;
        #1 check("t2_alu_ready2", 64'(bus.alu_ready), 64'd1);
        tick();
        idle_inputs();
        check("t2_w1", 64'({bus.rg_wrt_en, bus.rg_wrt_dest, bus.rg_wrt_data}), 64'({1'b1, 5'd3, 32'h11}));
        tick();
        check("t2_w2", 64'({bus.rg_wrt_en, bus.rg_wrt_dest, bus.rg_wrt_data}), 64'({1'b1, 5'd4, 32'h22}));
        tick();

        // Back-to-back stream of five writes
        for (int i = 0; i < 5; i++) begin
            alu_push(AW'(10 + i), DW'(32'h100 + i));
            tick();
        end
        idle_inputs();
        check("t3_dest13", 64'(bus.rg_wrt_dest), 64'd13);
        tick();
        check("t3_dest14", 64'(bus.rg_wrt_dest), 64'd14);
        check("t3_count",  64'(bus.count),       64'd0);
        tick();

        // x0 write is accepted and dropped
        alu_push(5'd0, 32'hFFFF_FFFF);
        #1 check("t4_ready", 64'(bus.alu_ready), 64'd1);
        tick();
        idle_inputs();
        check("t4_count", 64'(bus.count), 64'd0);
        tick();
        check("t4_en", 64'(bus.rg_wrt_en), 64'd0);

        // Forwarding picks the youngest pending value
        alu_push(5'd7, 32'hA);
        tick();
        alu_push(5'd7, 32'hB);
        tick();
        idle_inputs();
        bus.fwd_addr1 = 5'd7;
        bus.fwd_addr2 = 5'd0;
        #1 check("t5_hit1", 64'(bus.fwd_hit1), 64'(fwd_on));
        check("t5_data1", 64'(bus.fwd_data1), fwd_on ? 64'hB : 64'h0);
        check("t5_hit2",  64'(bus.fwd_hit2),  64'd0);
        tick();
        check("t5_out_hit", 64'(bus.fwd_hit1), 64'(fwd_on));
        tick();
        check("t5_gone", 64'(bus.fwd_hit1), 64'd0);

        // Reset in the middle of a stream
        for (int i = 0; i < 3; i++) begin
            alu_push(AW'(20 + i), DW'(32'h200 + i));
            tick();
        end
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_count", 64'(bus.count),     64'd0);
        check("t6_en",    64'(bus.rg_wrt_en), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_en_stay", 64'(bus.rg_wrt_en), 64'd0);
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            bus.ld_valid  = ($urandom_range(0, 99) < 35);
            bus.alu_valid = ($urandom_range(0, 99) < 55);
            bus.ld_dest   = AW'($urandom_range(0, 7));
            bus.alu_dest  = AW'($urandom_range(0, 7));
            bus.ld_data   = $urandom;
            bus.alu_data  = $urandom;
            bus.fwd_addr1 = AW'($urandom_range(0, 7));
            bus.fwd_addr2 = AW'($urandom_range(0, 7));
            rst_n         = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
